// File: rtl/axi_burst_addr_gen.sv
// AXI burst address generator.
// Pops request entries {id, addr, len, size, burst} from an upstream FIFO and
// expands each one into len+1 beat addresses using the AXI FIXED, INCR and
// WRAP rules. A new burst is loaded on the final handshake of the current one
// when the FIFO is non-empty, so consecutive bursts run with no idle cycle.
//
// Ports:
//   clk        - clock, all state on the rising edge
//   rst_n      - asynchronous active-low reset
//   req_empty  - upstream FIFO empty flag
//   req_data   - FIFO head entry {id, addr, len[7:0], size[2:0], burst[1:0]}
//   req_rd     - combinational pop strobe to the FIFO
//   beat_valid - beat address valid
//   beat_ready - downstream accepts the beat
//   beat_addr  - address of the current beat
//   beat_id    - ID of the current burst
//   beat_last  - current beat is the final beat of the burst
//   err        - sticky flag: an illegal WRAP length or reserved burst was seen
module axi_burst_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  localparam int unsigned ENTRY_W   = ID_WIDTH + ADDR_WIDTH + 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_empty,
  input  logic [ENTRY_W-1:0]    req_data,
  output logic                  req_rd,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [ID_WIDTH-1:0]   beat_id,
  output logic                  beat_last,
  output logic                  err
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  // FIFO head fields
  logic [ID_WIDTH-1:0]   head_id;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [7:0]            head_len;
  logic [2:0]            head_size;
  logic [1:0]            head_burst;

  assign head_burst = req_data[1:0];
  assign head_size  = req_data[4:2];
  assign head_len   = req_data[12:5];
  assign head_addr  = req_data[ADDR_WIDTH+12:13];
  assign head_id    = req_data[ENTRY_W-1:ADDR_WIDTH+13];

  logic wrap_len_ok;
  logic head_illegal;
  logic [1:0] head_burst_eff;

  assign wrap_len_ok = (head_len == 8'd1) || (head_len == 8'd3) ||
                       (head_len == 8'd7) || (head_len == 8'd15);
  assign head_illegal = (head_burst == 2'b11) || ((head_burst == BurstWrap) && !wrap_len_ok);
  // Illegal requests still complete, executed as INCR.
  assign head_burst_eff = head_illegal ? BurstIncr : head_burst;

  logic hs, is_last, final_hs, load;

  assign beat_valid = (state_q == StBurst);
  assign is_last    = (cnt_q == len_q);
  assign hs         = beat_valid && beat_ready;
  assign final_hs   = hs && is_last;
  assign load       = !req_empty && ((state_q == StIdle) || final_hs);
  // Gated by rst_n so the FIFO is never popped while reset is held.
  assign req_rd     = load && rst_n;

  // Next-beat address
  logic [ADDR_WIDTH-1:0] bytes, aligned, incr_addr, wsize, lower, wrap_addr, next_addr;

  always_comb begin
    bytes     = ADDR_WIDTH'(1) << size_q;
    aligned   = addr_q & ~(bytes - ADDR_WIDTH'(1));
    incr_addr = aligned + bytes;
    // len+1 is a power of two for any burst that is still WRAP here.
    wsize     = ADDR_WIDTH'({1'b0, len_q} + 9'd1) << size_q;
    lower     = addr_q & ~(wsize - ADDR_WIDTH'(1));
    wrap_addr = (incr_addr == (lower + wsize)) ? lower : incr_addr;
    case (burst_q)
      BurstFixed: next_addr = addr_q;
      BurstWrap:  next_addr = wrap_addr;
      default:    next_addr = incr_addr;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (load) begin
      state_d = StBurst;
      addr_d  = head_addr;
      id_d    = head_id;
      len_d   = head_len;
      size_d  = head_size;
      burst_d = head_burst_eff;
      cnt_d   = 8'd0;
      err_d   = err_q || head_illegal;
    end else if (final_hs) begin
      state_d = StIdle;
    end else if (hs) begin
      cnt_d  = cnt_q + 8'd1;
      addr_d = next_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign beat_addr = addr_q;
  assign beat_id   = id_q;
  assign beat_last = beat_valid && is_last;
  assign err       = err_q;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
module tb_axi_burst_addr_gen;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned EW = IW + AW + 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_empty;
  logic [EW-1:0] req_data;
  logic          req_rd;
  logic          beat_valid;
  logic          beat_ready;
  logic [AW-1:0] beat_addr;
  logic [IW-1:0] beat_id;
  logic          beat_last;
  logic          err;

  axi_burst_addr_gen #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_empty  (req_empty),
    .req_data   (req_data),
    .req_rd     (req_rd),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_addr  (beat_addr),
    .beat_id    (beat_id),
    .beat_last  (beat_last),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [EW-1:0] fifo_q[$];
  int            hs_cyc[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            rd_cnt = 0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_req(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    fifo_q.push_back({id, addr, len, size, burst});
  endtask

  task automatic exp_beat(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic last);
    beat_t b;
    b.addr = addr;
    b.id   = id;
    b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || beat_valid || fifo_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check({name, "_drain_timeout"}, 64'(n < 300), 64'd1);
    tick();
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!beat_valid && n < 50) begin
      tick();
      n++;
    end
    check({name, "_valid_timeout"}, 64'(beat_valid), 64'd1);
  endtask

  // Upstream FIFO model: pop decided from req_rd sampled mid-cycle.
  initial begin
    logic          pend;
    logic [EW-1:0] dummy;
    req_empty = 1'b1;
    req_data  = '0;
    forever begin
      @(negedge clk);
      pend = req_rd;
      @(posedge clk);
      #1;
      if (pend && fifo_q.size() > 0) dummy = fifo_q.pop_front();
      req_empty = (fifo_q.size() == 0);
      req_data  = req_empty ? '0 : fifo_q[0];
    end
  end

  // Monitor: compares every accepted beat with the scoreboard head.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && beat_valid && beat_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat_addr", 64'(beat_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("beat_addr", 64'(beat_addr), 64'(e.addr));
        check("beat_id", 64'(beat_id), 64'(e.id));
        check("beat_last", 64'(beat_last), 64'(e.last));
      end
      hs_cyc.push_back(cyc);
    end
    if (req_rd) rd_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0;
    rst_n      = 1'b0;
    beat_ready = 1'b1;

    // Reset state, with a request already waiting in the FIFO.
    push_req(4'h1, 32'h1000, 8'd3, 3'd2, 2'b01);
    exp_beat(32'h1000, 4'h1, 1'b0);
    exp_beat(32'h1004, 4'h1, 1'b0);
    exp_beat(32'h1008, 4'h1, 1'b0);
    exp_beat(32'h100C, 4'h1, 1'b1);
    repeat (3) tick();
    check("rst_empty_seen", 64'(req_empty), 64'd0);
    check("rst_req_rd", 64'(req_rd), 64'd0);
    check("rst_valid", 64'(beat_valid), 64'd0);
    check("rst_last", 64'(beat_last), 64'd0);
    check("rst_addr", 64'(beat_addr), 64'd0);
    check("rst_id", 64'(beat_id), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rd0 = rd_cnt;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // INCR aligned
    wait_drain("incr");
    check("incr_rd_pulses", 64'(rd_cnt - rd0), 64'd1);

    // WRAP legal
    push_req(4'h2, 32'h1008, 8'd3, 3'd2, 2'b10);
    exp_beat(32'h1008, 4'h2, 1'b0);
    exp_beat(32'h100C, 4'h2, 1'b0);
    exp_beat(32'h1000, 4'h2, 1'b0);
    exp_beat(32'h1004, 4'h2, 1'b1);
    wait_drain("wrap");
    check("wrap_err", 64'(err), 64'd0);

    // FIXED
    push_req(4'h3, 32'h20, 8'd2, 3'd2, 2'b00);
    exp_beat(32'h20, 4'h3, 1'b0);
    exp_beat(32'h20, 4'h3, 1'b0);
    exp_beat(32'h20, 4'h3, 1'b1);
    wait_drain("fixed");

    // INCR unaligned start
    push_req(4'h4, 32'h1003, 8'd2, 3'd2, 2'b01);
    exp_beat(32'h1003, 4'h4, 1'b0);
    exp_beat(32'h1004, 4'h4, 1'b0);
    exp_beat(32'h1008, 4'h4, 1'b1);
    wait_drain("unaligned");
    check("legal_err", 64'(err), 64'd0);

    // Stall mid-burst for 5 cycles
    beat_ready = 1'b0;
    push_req(4'h6, 32'h2000, 8'd3, 3'd2, 2'b01);
    exp_beat(32'h2000, 4'h6, 1'b0);
    exp_beat(32'h2004, 4'h6, 1'b0);
    exp_beat(32'h2008, 4'h6, 1'b0);
    exp_beat(32'h200C, 4'h6, 1'b1);
    wait_valid("stall");
    beat_ready = 1'b1;
    tick();
    beat_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(beat_valid), 64'd1);
      check("stall_addr", 64'(beat_addr), 64'h2004);
      check("stall_id", 64'(beat_id), 64'h6);
      check("stall_last", 64'(beat_last), 64'd0);
      tick();
    end
    beat_ready = 1'b1;
    wait_drain("stall");

    // Back-to-back bursts, no bubble
    rd0 = rd_cnt;
    hs_cyc.delete();
    push_req(4'h5, 32'h3000, 8'd3, 3'd2, 2'b01);
    push_req(4'h7, 32'h4008, 8'd3, 3'd3, 2'b10);
    exp_beat(32'h3000, 4'h5, 1'b0);
    exp_beat(32'h3004, 4'h5, 1'b0);
    exp_beat(32'h3008, 4'h5, 1'b0);
    exp_beat(32'h300C, 4'h5, 1'b1);
    exp_beat(32'h4008, 4'h7, 1'b0);
    exp_beat(32'h4010, 4'h7, 1'b0);
    exp_beat(32'h4018, 4'h7, 1'b0);
    exp_beat(32'h4000, 4'h7, 1'b1);
    wait_drain("b2b");
    check("b2b_rd_pulses", 64'(rd_cnt - rd0), 64'd2);
    check("b2b_beats", 64'(hs_cyc.size()), 64'd8);
    if (hs_cyc.size() == 8) check("b2b_span", 64'(hs_cyc[7] - hs_cyc[0]), 64'd7);

    // Reserved burst encoding
    push_req(4'h8, 32'h0, 8'd1, 3'd0, 2'b11);
    exp_beat(32'h0, 4'h8, 1'b0);
    exp_beat(32'h1, 4'h8, 1'b1);
    wait_drain("rsvd");
    check("rsvd_err", 64'(err), 64'd1);

    rst_n = 1'b0;
    tick();
    check("err_cleared", 64'(err), 64'd0);
    rst_n = 1'b1;
    tick();

    // WRAP with illegal length
    push_req(4'h9, 32'h100, 8'd2, 3'd2, 2'b10);
    exp_beat(32'h100, 4'h9, 1'b0);
    exp_beat(32'h104, 4'h9, 1'b0);
    exp_beat(32'h108, 4'h9, 1'b1);
    wait_drain("badwrap");
    check("badwrap_err", 64'(err), 64'd1);

    // Reset during beat 2 of a len 7 burst
    beat_ready = 1'b0;
    push_req(4'h3, 32'h5000, 8'd7, 3'd2, 2'b01);
    exp_beat(32'h5000, 4'h3, 1'b0);
    wait_valid("midrst");
    beat_ready = 1'b1;
    tick();
    beat_ready = 1'b0;
    check("midrst_beat2_addr", 64'(beat_addr), 64'h5004);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(beat_valid), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    check("midrst_addr", 64'(beat_addr), 64'd0);
    check("midrst_last", 64'(beat_last), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    beat_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_req_rd", 64'(req_rd), 64'd0);
      check("post_rst_valid", 64'(beat_valid), 64'd0);
    end
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
